dmem_access: RTL and testbench

DMEM_ACCESS -- requirements
Module: dmem_access

---
 rtl/dmem_access.sv | 184 ++++++++++++++++++
 tb/tb_dmem_access.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access.sv
// ---------------------------------------------------------------------------
// dmem_access -- data-memory access unit between the EX/MEM pipeline register
// and a single-port word memory with a one-cycle completion pulse (mem_ack).
//
// A load or store leaves IDLE for BUSY when it is aligned. In BUSY the request
// is presented on the mem_* bus until mem_ack arrives. DONE then lasts one
// cycle with stall low, and the FSM returns to IDLE. A misaligned access never
// leaves IDLE. Instead it raises misalign for as long as it is presented.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   MemRead, MemWrite   access request (both high = store)
//   addr, wdata         byte address, LSB-justified store data
//   dm_ctrl             access size (DM_* encodings below)
//   mem_req/we/addr/wstrb/wdata   registered memory request
//   mem_rdata, mem_ack  memory read data and completion pulse
//   stall               hold the upstream pipeline
//   raw_Data_out        last loaded word, selected lane shifted to bit 0
//   bias                registered addr[1:0] of the current access
//   misalign, bus_err   error indications
//   dbg_state           current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Optional feature: define DMEM_TIMEOUT_EN to end BUSY after 16 cycles
// without mem_ack. In that case bus_err pulses and the load returns 0.
//
// Handshake: the request registers load on the edge that leaves IDLE. They
// stay stable while mem_req=1. The memory completes the access by pulsing
// mem_ack for one cycle, and mem_ack is only honoured in BUSY.
// ---------------------------------------------------------------------------
module dmem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_ctrl,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [31:0] raw_Data_out,
  output logic [1:0]  bias,
  output logic        misalign,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  localparam logic [2:0] DM_WORD          = 3'd0;
  localparam logic [2:0] DM_HALFWORD      = 3'd1;
  localparam logic [2:0] DM_HALFWORD_UNS  = 3'd2;
  localparam logic [2:0] DM_BYTE          = 3'd3;
  localparam logic [2:0] DM_BYTE_UNS      = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [1:0]  bias_q;
  logic [31:0] raw_q;
  logic        start;
  logic        timeout;

  // Size decode. Unused encodings behave as word accesses.
  logic is_half, is_byte, is_word, access, mis;
  logic [3:0]  strb_c;
  logic [31:0] wdata_c;

  assign is_half = (dm_ctrl == DM_HALFWORD) || (dm_ctrl == DM_HALFWORD_UNS);
  assign is_byte = (dm_ctrl == DM_BYTE) || (dm_ctrl == DM_BYTE_UNS);
  assign is_word = !is_half && !is_byte;
  assign access  = MemRead || MemWrite;
  assign mis     = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));

  always_comb begin
    strb_c  = 4'b1111;
    wdata_c = wdata;
    if (is_byte) begin
      strb_c  = 4'b0001 << addr[1:0];
      wdata_c = {4{wdata[7:0]}};
    end else if (is_half) begin
      strb_c  = 4'b0011 << {addr[1], 1'b0};
      wdata_c = {2{wdata[15:0]}};
    end
  end

`ifdef DMEM_TIMEOUT_EN
  logic [3:0] cnt_q;
  logic       bus_err_q;
  assign timeout = (state_q == S_BUSY) && !mem_ack && (cnt_q == 4'd15);
  assign bus_err = bus_err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  // Next-state and combinational outputs.
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    misalign = 1'b0;
    start    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          if (mis) begin
            // Gated by rst so that misalign reads 0 while reset is held.
            misalign = rst;
          end else begin
            stall   = 1'b1;
            start   = 1'b1;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (mem_ack || timeout) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wstrb_q <= 4'd0;
      wdata_q <= 32'd0;
      bias_q  <= 2'd0;
      raw_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q  <= {addr[31:2], 2'b00};
        we_q    <= MemWrite;
        // Loads assert no byte-write strobes.
        wstrb_q <= MemWrite ? strb_c : 4'b0000;
        wdata_q <= wdata_c;
        bias_q  <= addr[1:0];
      end
      if (state_q == S_BUSY && !we_q) begin
        if (mem_ack) raw_q <= mem_rdata >> {bias_q, 3'b000};
        else if (timeout) raw_q <= 32'd0;
      end
    end
  end

`ifdef DMEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 4'd0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout;
      if (start) cnt_q <= 4'd0;
      else if (state_q == S_BUSY && !mem_ack) cnt_q <= cnt_q + 4'd1;
    end
  end
`endif

  assign mem_req      = (state_q == S_BUSY);
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wstrb    = wstrb_q;
  assign mem_wdata    = wdata_q;
  assign bias         = bias_q;
  assign raw_Data_out = raw_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_access.sv
module tb_dmem_access;

  localparam int RW = 71;  // {mem_addr, mem_we, mem_wstrb, mem_wdata, bias}
  localparam int DW = 34;  // {raw_Data_out, bus_err, stall}

  localparam logic [2:0] W  = 3'd0;
  localparam logic [2:0] H  = 3'd1;
  localparam logic [2:0] HU = 3'd2;
  localparam logic [2:0] B  = 3'd3;
  localparam logic [2:0] BU = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [31:0] addr, wdata;
  logic [2:0]  dm_ctrl;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic [31:0] raw_Data_out;
  logic [1:0]  bias;
  logic        misalign, bus_err;
  logic [1:0]  dbg_state;

  dmem_access dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .dm_ctrl(dm_ctrl),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .raw_Data_out(raw_Data_out), .bias(bias), .misalign(misalign),
    .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [RW-1:0] req_q[$];
  logic [DW-1:0] done_q[$];

  function automatic logic [RW-1:0] rq(input logic [31:0] a, input logic we,
                                       input logic [3:0] s, input logic [31:0] d,
                                       input logic [1:0] b);
    return {a, we, s, d, b};
  endfunction

  function automatic logic [DW-1:0] dn(input logic [31:0] raw, input logic be);
    return {raw, be, 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic prev_req = 1'b0;

  always @(negedge rst) prev_req = 1'b0;

  always @(negedge clk) begin
    logic [RW-1:0] ract, rexp;
    logic [DW-1:0] dact, dexp;
    if (rst === 1'b1) begin
      if (mem_req && !prev_req) begin
        ract = {mem_addr, mem_we, mem_wstrb, mem_wdata, bias};
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected got=%h", ract);
        end else begin
          rexp = req_q.pop_front();
          if (ract !== rexp) begin
            errors++;
            $display("FAIL req got=%h exp=%h", ract, rexp);
          end
        end
      end
      if (!mem_req && prev_req) begin
        dact = {raw_Data_out, bus_err, stall};
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected got=%h", dact);
        end else begin
          dexp = done_q.pop_front();
          if (dact !== dexp) begin
            errors++;
            $display("FAIL done got=%h exp=%h", dact, dexp);
          end
        end
      end
      prev_req = mem_req;
    end
  end

  // ---------------- driver tasks ----------------
  // ack_cyc: BUSY cycle (1-based) in which mem_ack is pulsed, 0 = never.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] ctrl,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int ack_cyc,
                            input int exp_stall, input logic [RW-1:0] ereq,
                            input logic [DW-1:0] edone);
    int  stall_cnt = 0;
    int  busy = 0;
    bit  done = 0;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; dm_ctrl = ctrl; addr = a; wdata = wd;
    req_q.push_back(ereq);
    done_q.push_back(edone);
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (c == 0) chk("misalign_aligned", {31'd0, misalign}, 32'd0);
      if (stall) stall_cnt++;
      if (mem_req) begin
        busy++;
        mem_ack   = (busy == ack_cyc);
        mem_rdata = (busy == ack_cyc) ? rdat : 32'hBADBADBA;
      end else begin
        mem_ack = 1'b0;
      end
      if (!stall && stall_cnt > 0) done = 1;
    end
    mem_ack = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout got=stall_cycles_%0d exp=done", stall_cnt);
    end
    chk("stall_cycles", stall_cnt, exp_stall);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic run_mis(input logic rd, input logic wr, input logic [2:0] ctrl,
                         input logic [31:0] a);
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; dm_ctrl = ctrl; addr = a; wdata = 32'h0;
    @(negedge clk);
    chk("misalign_pulse", {31'd0, misalign}, 32'd1);
    chk("misalign_stall", {31'd0, stall}, 32'd0);
    chk("misalign_req",   {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    chk("misalign_stay_idle", {31'd0, mem_req}, 32'd0);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    chk("misalign_clear", {31'd0, misalign}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = 32'h0; wdata = 32'h0;
    dm_ctrl = W; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req",  {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we",   {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_bias",     {30'd0, bias}, 32'd0);
    chk("rst_raw",      raw_Data_out, 32'd0);
    chk("rst_bus_err",  {31'd0, bus_err}, 32'd0);
    chk("rst_stall_idle", {31'd0, stall}, 32'd0);
    // During reset stall follows the inputs, misalign stays low.
    MemRead = 1'b1; addr = 32'h100; #1;
    chk("rst_stall_follows", {31'd0, stall}, 32'd1);
    addr = 32'h101; #1;
    chk("rst_misalign_low", {31'd0, misalign}, 32'd0);
    MemRead = 1'b0; addr = 32'h0;
    @(posedge clk); #1 rst = 1'b1;

    // Word load, ack in 3rd BUSY cycle.
    run_access(1, 0, W, 32'h100, 32'h0, 32'hDEADBEEF, 3, 4,
               rq(32'h100, 0, 4'h0, 32'h0, 2'd0), dn(32'hDEADBEEF, 0));
    // Byte store to lane 3.
    run_access(0, 1, B, 32'h103, 32'h000000A5, 32'h0, 1, 2,
               rq(32'h100, 1, 4'b1000, 32'hA5A5A5A5, 2'd3), dn(32'hDEADBEEF, 0));
    // Halfword load, upper half.
    run_access(1, 0, H, 32'h102, 32'h0, 32'h80011234, 2, 3,
               rq(32'h100, 0, 4'h0, 32'h0, 2'd2), dn(32'h00008001, 0));
    // Read and write both high: store wins.
    run_access(1, 1, HU, 32'h106, 32'h1234BEEF, 32'h77777777, 1, 2,
               rq(32'h104, 1, 4'b1100, 32'hBEEFBEEF, 2'd2), dn(32'h00008001, 0));
    // Unsigned byte load from lane 1.
    run_access(1, 0, BU, 32'h201, 32'h0, 32'h11223344, 1, 2,
               rq(32'h200, 0, 4'h0, 32'h0, 2'd1), dn(32'h00112233, 0));
    // Word store.
    run_access(0, 1, W, 32'h30C, 32'hCAFEF00D, 32'h0, 2, 3,
               rq(32'h30C, 1, 4'hF, 32'hCAFEF00D, 2'd0), dn(32'h00112233, 0));

    // mem_ack while IDLE must be ignored.
    @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_state", {30'd0, dbg_state}, 32'd0);
    chk("stray_ack_raw", raw_Data_out, 32'h00112233);

    // Misaligned accesses.
    run_mis(1, 0, W,  32'h101);
    run_mis(0, 1, H,  32'h205);
    run_mis(1, 0, HU, 32'h003);

`ifdef DMEM_TIMEOUT_EN
    run_access(1, 0, W, 32'h400, 32'h0, 32'h55AA55AA, 0, 17,
               rq(32'h400, 0, 4'h0, 32'h0, 2'd0), dn(32'h0, 1));
`else
    run_access(1, 0, W, 32'h400, 32'h0, 32'h55AA55AA, 20, 21,
               rq(32'h400, 0, 4'h0, 32'h0, 2'd0), dn(32'h55AA55AA, 0));
`endif

    // Reset in BUSY, then a late mem_ack.
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; dm_ctrl = W; addr = 32'h200; wdata = 32'h0;
    req_q.push_back(rq(32'h200, 0, 4'h0, 32'h0, 2'd0));
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_busy_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_busy_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_busy_raw",   raw_Data_out, 32'd0);
    chk("rst_busy_addr",  mem_addr, 32'd0);
    MemRead = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk); mem_ack = 1'b0;
    chk("late_ack_raw",   raw_Data_out, 32'd0);
    chk("late_ack_req",   {31'd0, mem_req}, 32'd0);
    chk("late_ack_state", {30'd0, dbg_state}, 32'd0);

    repeat (2) @(negedge clk);
    chk("req_q_empty",  req_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
